// File: rtl/ad9945_cfg_rx.sv
// AD9945 3-wire configuration port receiver: oversamples SL/SCK/SDATA on sys_clk,
// decodes SL-framed LSB-first writes and holds the Oper/Ctrl/Clamp/VGA_Gain registers.
module ad9945_cfg_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        SL,
  input  logic        SCK,
  input  logic        SDATA,
  output logic [6:0]  oper,
  output logic [6:0]  ctrl,
  output logic [7:0]  clamp,
  output logic [9:0]  vga_gain,
  output logic        wr_valid,
  output logic [2:0]  wr_addr,
  output logic [10:0] wr_data,
  output logic        frame_err,
  output logic        cfg_done
);

  typedef enum logic [1:0] {StArm, StIdle, StShift, StCommit} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sl_sync, sck_sync, sd_sync;
  logic                   sl_prev, sck_prev;
  logic                   sl_s, sck_s, sd_s, sl_rise, sck_rise;
  logic [4:0]             bit_cnt;
  // Index 13 is never part of any data field, so only indices 0..12 are kept.
  logic [12:0]            shreg;
  logic [3:0]             seen, seen_next;
  logic [2:0]             addr;
  logic [3:0]             data_w;
  logic [9:0]             wdata;
  logic                   frame_ok;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sl_sync  <= '0;
      sck_sync <= '0;
      sd_sync  <= '0;
      sl_prev  <= 1'b0;
      sck_prev <= 1'b0;
    end else begin
      sl_sync  <= {sl_sync[SYNC_STAGES-2:0], SL};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], SDATA};
      sl_prev  <= sl_s;
      sck_prev <= sck_s;
    end
  end

  assign sl_s     = sl_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sd_s     = sd_sync[SYNC_STAGES-1];
  assign sl_rise  = sl_s & ~sl_prev;
  assign sck_rise = sck_s & ~sck_prev;
  assign addr     = shreg[2:0];

  always_comb begin
    data_w = 4'd10;
    wdata  = shreg[12:3];
    case (addr[1:0])
      2'd0, 2'd1: begin
        data_w = 4'd7;
        wdata  = {3'b000, shreg[9:3]};
      end
      2'd2: begin
        data_w = 4'd8;
        wdata  = {2'b00, shreg[10:3]};
      end
      default: ;
    endcase
    frame_ok  = ~addr[2] && (bit_cnt >= 5'd3 + {1'b0, data_w});
    seen_next = seen | (4'b0001 << addr[1:0]);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state     <= StArm;
      bit_cnt   <= '0;
      shreg     <= '0;
      seen      <= '0;
      oper      <= '0;
      ctrl      <= '0;
      clamp     <= '0;
      vga_gain  <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        StArm: if (sl_s) state <= StIdle;
        StIdle: begin
          if (!sl_s) begin
            bit_cnt <= '0;
            shreg   <= '0;
            state   <= StShift;
          end
        end
        StShift: begin
          // SL rising takes priority over a coincident SCK edge.
          if (sl_rise) begin
            state <= StCommit;
          end else if (sck_rise) begin
            if (bit_cnt < 5'd13) shreg[bit_cnt[3:0]] <= sd_s;
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        StCommit: begin
          state <= StIdle;
          if (bit_cnt != 5'd0) begin
            if (frame_ok) begin
              case (addr[1:0])
                2'd0:    oper     <= wdata[6:0];
                2'd1:    ctrl     <= wdata[6:0];
                2'd2:    clamp    <= wdata[7:0];
                default: vga_gain <= wdata;
              endcase
              wr_valid <= 1'b1;
              wr_addr  <= addr;
              wr_data  <= {1'b0, wdata};
              seen     <= seen_next;
              if (&seen_next) cfg_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= StArm;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9945_cfg_rx.sv
// Self-checking bench for ad9945_cfg_rx: directed and random frames against a
// frame-level reference model of the register file.
module tb_ad9945_cfg_rx;
  localparam int SS = 2;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        SL = 1'b1;
  logic        SCK = 1'b0;
  logic        SDATA = 1'b0;
  logic [6:0]  oper, ctrl;
  logic [7:0]  clamp;
  logic [9:0]  vga_gain;
  logic        wr_valid, frame_err, cfg_done;
  logic [2:0]  wr_addr;
  logic [10:0] wr_data;

  ad9945_cfg_rx #(.SYNC_STAGES(SS)) dut (
    .sys_clk(sys_clk), .reset(reset), .SL(SL), .SCK(SCK), .SDATA(SDATA),
    .oper(oper), .ctrl(ctrl), .clamp(clamp), .vga_gain(vga_gain),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .cfg_done(cfg_done)
  );

  always #5 sys_clk = ~sys_clk;

  int passed = 0;
  int total = 0;
  int nv, ne, lat;
  logic done_at_pulse;

  // Reference model state
  logic [6:0]  m_oper, m_ctrl;
  logic [7:0]  m_clamp;
  logic [9:0]  m_vga;
  logic [2:0]  m_addr;
  logic [10:0] m_data;
  logic [3:0]  m_seen;
  int          m_v, m_e;

  function automatic logic [46:0] obs();
    return {oper, ctrl, clamp, vga_gain, wr_addr, wr_data, cfg_done};
  endfunction

  function automatic logic [46:0] expv();
    return {m_oper, m_ctrl, m_clamp, m_vga, m_addr, m_data, (m_seen == 4'hF)};
  endfunction

  task automatic model_reset();
    m_oper = '0; m_ctrl = '0; m_clamp = '0; m_vga = '0;
    m_addr = '0; m_data = '0; m_seen = '0;
  endtask

  // n counts only the SCK rises the receiver should accept.
  task automatic model_frame(input logic [31:0] bits, input int n);
    int a, w, d;
    a = int'(bits[2:0]);
    w = (a < 2) ? 7 : (a == 2) ? 8 : 10;
    m_v = 0;
    m_e = 0;
    if (n == 0) begin
    end else if (a < 4 && n >= 3 + w) begin
      d = int'(bits >> 3) & ((1 << w) - 1);
      m_v = 1;
      case (a)
        0: m_oper = d[6:0];
        1: m_ctrl = d[6:0];
        2: m_clamp = d[7:0];
        default: m_vga = d[9:0];
      endcase
      m_addr = a[2:0];
      m_data = d[10:0];
      m_seen[a] = 1'b1;
    end else begin
      m_e = 1;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic start_frame();
    SL = 1'b0;
    wait_clk(SS + 3);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      SDATA = bits[i];
      wait_clk(2);
      SCK = 1'b1;
      wait_clk(4);
      SCK = 1'b0;
      wait_clk(2);
    end
  endtask

  // Raises SL (optionally together with an SCK rise) and records the pulses that follow.
  task automatic end_frame(input bit coincide);
    SDATA = 1'b1;
    wait_clk(2);
    if (coincide) SCK = 1'b1;
    SL = 1'b1;
    nv = 0; ne = 0; lat = -1; done_at_pulse = 1'b0;
    for (int c = 1; c <= SS + 10; c++) begin
      @(negedge sys_clk);
      if (wr_valid) begin
        nv++;
        done_at_pulse = cfg_done;
        if (lat < 0) lat = c;
      end
      if (frame_err) begin
        ne++;
        if (lat < 0) lat = c;
      end
    end
    SCK = 1'b0;
    wait_clk(4);
  endtask

  task automatic run_frame(input logic [31:0] bits, input int n, input bit coincide);
    start_frame();
    send_bits(bits, 0, n);
    end_frame(coincide);
    model_frame(bits, n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clk(3);
    total++;
    if (obs() !== 47'd0 || wr_valid !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL reset_state: got %h v=%b e=%b required 0", obs(), wr_valid, frame_err);
    else passed++;
    reset = 1'b0;
    model_reset();
    wait_clk(6);
  endtask

  task automatic test_oper();
    run_frame(32'h2A8, 10, 1'b0);
    total++;
    if (nv !== 1 || ne !== 0 || lat !== SS + 2)
      $display("FAIL oper_write: valid=%0d err=%0d lat=%0d required 1 0 %0d", nv, ne, lat, SS + 2);
    else passed++;
    total++;
    if (obs() !== expv() || oper !== 7'h55 || wr_data !== 11'h055)
      $display("FAIL oper_regs: got %h required %h", obs(), expv());
    else passed++;
  endtask

  task automatic test_all_regs();
    logic [31:0] fr [3];
    int len [3];
    fr[0] = 32'h2A9; len[0] = 10;
    fr[1] = 32'h2AA; len[1] = 11;
    fr[2] = 32'hAAB; len[2] = 13;
    for (int k = 0; k < 3; k++) begin
      run_frame(fr[k], len[k], 1'b0);
      total++;
      if (nv !== 1 || ne !== 0 || done_at_pulse !== (k == 2))
        $display("FAIL all_regs_%0d: valid=%0d err=%0d done=%b required 1 0 %b",
                 k, nv, ne, done_at_pulse, (k == 2));
      else passed++;
      total++;
      if (obs() !== expv())
        $display("FAIL all_regs_state_%0d: got %h required %h", k, obs(), expv());
      else passed++;
    end
    total++;
    if (ctrl !== 7'h55 || clamp !== 8'h55 || vga_gain !== 10'h155 || cfg_done !== 1'b1)
      $display("FAIL all_regs_values: got %h %h %h %b required 55 55 155 1",
               ctrl, clamp, vga_gain, cfg_done);
    else passed++;
  endtask

  task automatic test_short_and_bad_addr();
    run_frame(32'h2AA, 7, 1'b0);
    total++;
    if (nv !== 0 || ne !== 1 || lat !== SS + 2 || obs() !== expv())
      $display("FAIL short_frame: valid=%0d err=%0d lat=%0d regs %h required 0 1 %0d %h",
               nv, ne, lat, obs(), SS + 2, expv());
    else passed++;
    run_frame(32'h3FFD, 14, 1'b0);
    total++;
    if (nv !== 0 || ne !== 1 || obs() !== expv())
      $display("FAIL bad_addr: valid=%0d err=%0d regs %h required 0 1 %h",
               nv, ne, obs(), expv());
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    start_frame();
    send_bits(32'h2A8, 0, 6);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    model_reset();
    send_bits(32'h2A8, 6, 10);
    end_frame(1'b0);
    total++;
    if (nv !== 0 || ne !== 0 || obs() !== 47'd0)
      $display("FAIL reset_drop: valid=%0d err=%0d regs %h required 0 0 0", nv, ne, obs());
    else passed++;
    run_frame(32'h150, 10, 1'b0);
    total++;
    if (nv !== 1 || ne !== 0 || oper !== 7'h2A || obs() !== expv())
      $display("FAIL after_reset: valid=%0d err=%0d regs %h required 1 0 %h",
               nv, ne, obs(), expv());
    else passed++;
  endtask

  task automatic test_long_and_coincident();
    run_frame(32'h3C199, 18, 1'b0);
    total++;
    if (nv !== 1 || ne !== 0 || ctrl !== 7'h33 || obs() !== expv())
      $display("FAIL long_frame: valid=%0d err=%0d regs %h required 1 0 %h",
               nv, ne, obs(), expv());
    else passed++;
    // Nine accepted bits plus a tenth whose SCK rise coincides with SL rising.
    run_frame(32'h3FF8, 9, 1'b1);
    total++;
    if (nv !== 0 || ne !== 1 || obs() !== expv())
      $display("FAIL coincident_edge: valid=%0d err=%0d regs %h required 0 1 %h",
               nv, ne, obs(), expv());
    else passed++;
  endtask

  task automatic test_idle_sck();
    nv = 0; ne = 0;
    for (int i = 0; i < 3; i++) begin
      SCK = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge sys_clk);
        if (wr_valid) nv++;
        if (frame_err) ne++;
      end
      SCK = 1'b0;
      wait_clk(4);
    end
    total++;
    if (nv !== 0 || ne !== 0 || obs() !== expv())
      $display("FAIL idle_sck: valid=%0d err=%0d regs %h required 0 0 %h",
               nv, ne, obs(), expv());
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] bits;
    int n;
    bit co;
    for (int k = 0; k < 30; k++) begin
      bits = $urandom;
      if ($urandom_range(0, 1) == 1) bits[2] = 1'b0;
      n = int'($urandom_range(0, 18));
      co = ($urandom_range(0, 4) == 0);
      run_frame(bits, n, co);
      total++;
      if (nv !== m_v || ne !== m_e || ((m_v + m_e) != 0 && lat !== SS + 2))
        $display("FAIL random_%0d pulses (bits=%h n=%0d co=%0d): valid=%0d err=%0d lat=%0d required %0d %0d",
                 k, bits, n, co, nv, ne, lat, m_v, m_e);
      else passed++;
      total++;
      if (obs() !== expv())
        $display("FAIL random_%0d regs (bits=%h n=%0d): got %h required %h",
                 k, bits, n, obs(), expv());
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_oper();
    test_all_regs();
    test_short_and_bad_addr();
    test_reset_mid_frame();
    test_long_and_coincident();
    test_idle_sck();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ad9945_cfg_rx.md
# ad9945_cfg_rx

Synthesizable receiver for the AD9945 3-wire serial configuration port (SL/SCK/SDATA), i.e. the register-side end of the link driven by the TCD1209D block's AD9945 configuration logic. It oversamples the serial lines on the system clock, decodes each SL-framed write into an address and data word, and holds the Oper, Ctrl, Clamp and VGA_Gain registers. It serves as the loop-back checker in CCD simulation benches and as the front end of a synthesizable AFE emulator.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop stages on each of SL, SCK and SDATA; minimum 2.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge. Reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high reset.
- SL  in  1  frame strobe; active low. A frame spans from SL falling to SL rising.
- SCK  in  1  serial clock; SDATA is sampled on the SCK rising edge.
- SDATA  in  1  serial data.
- oper  out  7  register at address 0.
- ctrl  out  7  register at address 1.
- clamp  out  8  register at address 2.
- vga_gain  out  10  register at address 3.
- wr_valid  out  1  one-cycle pulse on each accepted write.
- wr_addr  out  3  address of the last accepted write.
- wr_data  out  11  data of the last accepted write, zero-extended.
- frame_err  out  1  one-cycle pulse on each rejected frame.
- cfg_done  out  1  sticky; set once all four addresses have been written since reset.

## Operation
- Each input passes through a SYNC_STAGES synchronizer. Edge detection runs on the synchronized copies.
- Frame format, LSB first: 3 address bits A0..A2, then data bits D0..D(W-1).
- Data width W is 7, 7, 8 and 10 for addresses 0, 1, 2 and 3. Addresses 4–7 are invalid.
- Bits are indexed by bit_cnt. Bits at index 14 and above are ignored, and the frame is not rejected for them.
- bit_cnt is 5 bits wide and saturates at 31.
- State IDLE: wait for synchronized SL low, then clear bit_cnt and the shift register and go to SHIFT.
- State SHIFT: on each synchronized SCK rising edge, store SDATA at bit_cnt (if below 14) and increment bit_cnt. On synchronized SL rising, go to COMMIT.
- State COMMIT lasts one cycle and decides the frame, then returns to IDLE:
  - bit_cnt = 0: no action.
  - Valid address and bit_cnt ≥ 3+W: load the register from D0..D(W-1), pulse wr_valid, and update wr_addr and wr_data.
  - Otherwise: pulse frame_err and leave all registers unchanged.
- If an SCK rising edge and an SL rising edge are detected in the same cycle, SL wins and the SCK edge is discarded.
- SCK edges while SL is high are ignored.
- On reset: every output is 0 (oper, ctrl, clamp, vga_gain, wr_addr, wr_data, wr_valid, frame_err, cfg_done) and the state is ARM.
- State ARM: after reset, wait until synchronized SL has been seen high, then go to IDLE. A frame already in progress when reset deasserts is dropped silently, with no frame_err.
- cfg_done is set in the cycle its fourth distinct address is committed. Only reset clears it.

## Timing
- Latency: registers, wr_valid and wr_addr/wr_data update SYNC_STAGES+1 sys_clk cycles after the first sys_clk edge that samples raw SL high.
- wr_valid and frame_err are exactly one cycle wide. At most one of them asserts per frame.
- Input constraints:
  - SCK high and SCK low each last at least SYNC_STAGES+1 sys_clk periods.
  - SDATA is stable from 1 sys_clk period before to SYNC_STAGES+1 periods after the SCK rising edge.
  - SL is low at least SYNC_STAGES+1 periods before the first SCK rise, and high at least SYNC_STAGES+2 periods between frames.
- Register outputs change only in the COMMIT cycle. Between commits they are held.

## Test plan
1. Addr 0, data 7'b1010101 (10 bits) -> oper = 7'h55; one wr_valid pulse with wr_addr = 0 and wr_data = 11'h055; frame_err stays 0.
2. Writes to addr 1 = 7'h55, addr 2 = 8'h55, addr 3 = 10'h155 after test 1 -> ctrl = 7'h55, clamp = 8'h55, vga_gain = 10'h155; cfg_done rises with the addr 3 commit and stays high.
3. Addr 2 with only 4 data bits (7 bits total) -> one frame_err pulse; clamp unchanged; no wr_valid.
4. Addr 5 with a full 14-bit frame -> one frame_err pulse; no register change; wr_addr and wr_data unchanged.
5. Reset asserted after 6 bits of an addr 0 frame and released with SL still low; remaining bits clocked; SL rises -> no wr_valid, no frame_err, oper = 0. A following full addr 0 frame with data 7'h2A -> oper = 7'h2A.
6. Addr 1 frame of 18 bits with D0..D6 = 7'h33 and bits 14–17 = 1 -> ctrl = 7'h33; wr_valid pulses; no frame_err. Separately, an SL rise coincident with an SCK rise -> that bit is not counted.
